// File: rtl/space_invaders_pkg.sv
// Shared types and constants for the space-invaders fleet logic.
package space_invaders_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MARCH   = 3'd1,
    ST_DROP    = 3'd2,
    ST_CLEARED = 3'd3,
    ST_OVER    = 3'd4
  } march_state_t;

endpackage

// File: rtl/enemy_march_ctrl_if.sv
// Movement bus between the game-state logic, the march controller and the sprite array.
interface enemy_march_ctrl_if;
  import space_invaders_pkg::*;

  // game_start and hit are single-cycle pulses sampled on the next Clk edge; there is
  // no back-pressure, every outgoing signal is a registered level valid on every cycle.
  logic         game_start;
  logic         hit;
  logic         start;
  logic         enemy_direction_X;
  logic         enemy_direction_Y;
  logic         delete_enemies;
  logic [9:0]   fleet_x;
  logic [9:0]   fleet_y;
  logic [7:0]   alive;
  logic         wave_cleared;
  logic         game_over;
  march_state_t state_dbg;

  modport master (
    input  game_start, hit,
    output start, enemy_direction_X, enemy_direction_Y, delete_enemies,
    output fleet_x, fleet_y, alive, wave_cleared, game_over, state_dbg
  );

  modport slave (
    output game_start, hit,
    input  start, enemy_direction_X, enemy_direction_Y, delete_enemies,
    input  fleet_x, fleet_y, alive, wave_cleared, game_over, state_dbg
  );

endinterface

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous frame strobe into the Clk domain as a one-cycle tick.
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = frame_clk;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign tick = s2_q & ~s3_q;

endmodule

// File: rtl/enemy_march_ctrl.sv
// Fleet march controller: mirrors the fleet bounding box, turns and drops it at the
// screen edges, counts kills and ends the wave on clear or on reaching the player line.
module enemy_march_ctrl
  import space_invaders_pkg::*;
#(
  parameter logic [9:0] FLEET_X0     = 10'd40,
  parameter logic [9:0] FLEET_Y0     = 10'd40,
  parameter logic [9:0] FLEET_WIDTH  = 10'd300,
  parameter logic [9:0] FLEET_HEIGHT = 10'd150,
  parameter logic [9:0] LEFT_BOUND   = 10'd0,
  parameter logic [9:0] RIGHT_BOUND  = 10'd639,
  parameter logic [9:0] LOSE_Y       = 10'd400,
  parameter logic [3:0] DROP_ROWS    = 4'd8,
  parameter logic [7:0] NUM_ENEMIES  = 8'd24
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  enemy_march_ctrl_if.master bus
);

  localparam logic [2:0] S_IDLE    = 3'(ST_IDLE);
  localparam logic [2:0] S_MARCH   = 3'(ST_MARCH);
  localparam logic [2:0] S_DROP    = 3'(ST_DROP);
  localparam logic [2:0] S_CLEARED = 3'(ST_CLEARED);
  localparam logic [2:0] S_OVER    = 3'(ST_OVER);

  logic tick;

  frame_tick_sync u_sync (
    .Clk      (Clk),
    .Reset    (Reset),
    .frame_clk(frame_clk),
    .tick     (tick)
  );

  logic [2:0] state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [7:0] alive_q, alive_d;
  logic       dx_q, dx_d;
  logic       dy_q, dy_d;
  logic [3:0] cnt_q, cnt_d;
  logic       start_q, start_d;
  logic       del_q, del_d;
  logic       wc_q, wc_d;
  logic       go_q, go_d;
  logic       over_hit;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    alive_d  = alive_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    cnt_d    = cnt_q;
    over_hit = 1'b0;

    if (bus.game_start) begin
      x_d     = FLEET_X0;
      y_d     = FLEET_Y0;
      alive_d = NUM_ENEMIES;
      dx_d    = DIR_RIGHT;
      dy_d    = 1'b0;
      cnt_d   = 4'd0;
      state_d = S_MARCH;
    end else if (state_q == S_MARCH || state_q == S_DROP) begin
      if (tick) begin
        // Mirror the step the sprites just took with the directions they were given.
        if (dx_q == DIR_RIGHT) x_d = x_q + 10'd1;
        else if (x_q != 10'd0) x_d = x_q - 10'd1;
        if (dy_q) y_d = y_q + 10'd1;

        if (state_q == S_MARCH) begin
          if (dx_q == DIR_RIGHT &&
              ({1'b0, x_d} + {1'b0, FLEET_WIDTH}) >= {1'b0, RIGHT_BOUND}) begin
            dx_d    = DIR_LEFT;
            dy_d    = 1'b1;
            cnt_d   = DROP_ROWS;
            state_d = S_DROP;
          end else if (dx_q == DIR_LEFT && x_d <= LEFT_BOUND) begin
            dx_d    = DIR_RIGHT;
            dy_d    = 1'b1;
            cnt_d   = DROP_ROWS;
            state_d = S_DROP;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_d == 4'd0) begin
            dy_d    = 1'b0;
            state_d = S_MARCH;
          end
        end

        over_hit = ({1'b0, y_d} + {1'b0, FLEET_HEIGHT}) >= {1'b0, LOSE_Y};
      end

      if (bus.hit && alive_q != 8'd0) alive_d = alive_q - 8'd1;

      // Killing the last enemy wins even if the fleet touches the line on the same frame.
      if (bus.hit && alive_d == 8'd0) state_d = S_CLEARED;
      else if (over_hit)               state_d = S_OVER;
    end
  end

  always_comb begin
    start_d = (state_d == S_MARCH) || (state_d == S_DROP);
    del_d   = (state_d == S_CLEARED) || (state_d == S_OVER);
    wc_d    = (state_d == S_CLEARED);
    go_d    = (state_d == S_OVER);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      x_q     <= FLEET_X0;
      y_q     <= FLEET_Y0;
      alive_q <= NUM_ENEMIES;
      dx_q    <= DIR_RIGHT;
      dy_q    <= 1'b0;
      cnt_q   <= 4'd0;
      start_q <= 1'b0;
      del_q   <= 1'b0;
      wc_q    <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      alive_q <= alive_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      del_q   <= del_d;
      wc_q    <= wc_d;
      go_q    <= go_d;
    end
  end

  assign bus.start             = start_q;
  assign bus.enemy_direction_X = dx_q;
  assign bus.enemy_direction_Y = dy_q;
  assign bus.delete_enemies    = del_q;
  assign bus.fleet_x           = x_q;
  assign bus.fleet_y           = y_q;
  assign bus.alive             = alive_q;
  assign bus.wave_cleared      = wc_q;
  assign bus.game_over         = go_q;
  assign bus.state_dbg         = march_state_t'(state_q);

endmodule
